inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Fetch-stage PC and instruction-request controller for the five-stage MIPS core with the sram-like bus. It holds the fetch PC and drives the instruction sram-like request. It buffers the returned word for decode. It applies branch/jump redirects produced by the decode-stage comparator and jump logic, after the delay slot, and applies exception redirects immediately, discarding any in-flight fetch.

## Interface
Parameters:
- RESET_PC, 32'hbfc00000, PC fetched first after reset.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- stallF  in  1  hazard unit holds F/D; buffered instruction must not be consumed.
- redirectD  in  1  one-cycle pulse: decode resolved a taken branch or jump.
- redirect_targetD  in  32  target for redirectD.
- flush_excep  in  1  exception/eret redirect, highest priority.
- excep_pc  in  32  target for flush_excep.
- inst_req  out  1  sram-like request.
- inst_wr  out  1  constant 0.
- inst_size  out  2  constant 2'b10.
- inst_addr  out  32  request address (= pcF).
- inst_wdata  out  32  constant 0.
- inst_addr_ok  in  1  address accepted.
- inst_data_ok  in  1  read data valid.
- inst_rdata  in  32  read data.
- pcF  out  32  PC of the instruction being fetched or held.
- instF  out  32  buffered instruction, valid when inst_validF.
- inst_validF  out  1  instF holds a deliverable instruction.
- adelF  out  1  pcF misaligned; delivered with instF=0.
- fetch_busy  out  1  = !inst_validF; stall request to the hazard unit.

## Operation
- States: BOOT, REQ, DATA, OUT, DROP.
- BOOT: reset state. inst_req=0. Goes to REQ next cycle.
- REQ: inst_req=1, inst_addr=pcF.
  - If pcF[1:0]!=0: no request is issued (inst_req=0); load instF=0, set adelF, go to OUT.
  - On inst_addr_ok: go to DATA, or to DROP if kill is set or flush_excep is asserted.
  - Once raised, inst_req and inst_addr stay stable until inst_addr_ok, even on flush.
- DATA: on inst_data_ok:
  - If neither kill nor flush_excep: capture inst_rdata into instF and go to OUT.
  - Otherwise discard the data and go to REQ at the flush PC.
  - flush_excep without inst_data_ok: go to DROP.
- DROP: wait for inst_data_ok, discard the data, clear kill, go to REQ.
- OUT: inst_validF=1. When !stallF (consumed): pcF <= next_pc, go to REQ.
- next_pc, in priority order:
  1. pending redirect target (clears pending);
  2. redirect_targetD, if redirectD is asserted in the consuming cycle;
  3. pcF+4.
- redirectD in any other cycle: latch target into pending, to be applied at the next consumption. That consumption delivers the delay slot.
- A second redirectD while pending is valid is a protocol error; the later target overwrites.
- flush_excep, any state: pcF <= excep_pc, pending cleared, adelF cleared.
  - BOOT/OUT: go to REQ.
  - REQ not yet accepted: set kill; the request completes, its data is discarded.
  - REQ/DATA: handled by the transitions above.
- pcF+4 wraps modulo 2^32.

## Timing
- Reset values:
  - state=BOOT, pcF=RESET_PC, inst_req=0, inst_validF=0, instF=0, adelF=0, fetch_busy=1.
  - pending and kill cleared.
- Reset mid-transaction abandons the transaction. The bus is reset together with the core.
- Minimum latency with zero-wait bus:
  - REQ (addr_ok) in cycle n, data_ok in n+1, inst_validF in n+2.
  - Throughput: one instruction per 3 cycles.
- instF/pcF are stable while inst_validF=1 and stallF=1.
- Redirect to the target is visible on inst_addr in the cycle after consumption of the delay slot.
- flush_excep in OUT: inst_validF drops and inst_addr=excep_pc in the next cycle.

## Test plan
- Reset release, zero-wait bus returning 32'h24080001 at 32'hbfc00000: first inst_req in cycle 1 after reset with addr bfc00000; inst_validF=1 with that word; next inst_addr bfc00004.
- stallF held 5 cycles in OUT: instF/pcF unchanged, no new inst_req; release gives addr pcF+4.
- Branch at bfc00010 with redirectD (target bfc00100) while the delay slot bfc00014 is still in DATA: bfc00014 is delivered, then inst_addr=bfc00100. Repeat with redirectD in the consuming cycle: same sequence.
- flush_excep (excep_pc=bfc00380) in REQ with addr_ok delayed 3 cycles: inst_addr held at the old PC until addr_ok; the returned data is discarded and never valid; next request is bfc00380.
- flush_excep in DATA coinciding with data_ok: data dropped; next cycle REQ at bfc00380. flush also cancels a pending redirect.
- redirect_targetD=bfc00102: after the delay slot, adelF=1, instF=0, inst_validF=1, no bus request issued.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Fetch-stage PC and instruction-request controller for a five-stage MIPS core
// on an sram-like instruction bus. Holds the fetch PC, issues one read at a
// time, buffers the returned word for decode, applies branch/jump redirects
// after the delay slot and exception redirects immediately.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   stallF              decode not ready; buffered instruction is held
//   redirectD           taken branch/jump pulse from decode
//   redirect_targetD    target for redirectD
//   flush_excep         exception/eret redirect (highest priority)
//   excep_pc            target for flush_excep
//   inst_req/wr/size/addr/wdata      sram-like request side
//   inst_addr_ok/data_ok/rdata       sram-like response side
//   pcF, instF, inst_validF, adelF   fetch result towards decode
//   fetch_busy          stall request to the hazard unit (= !inst_validF)
//
// state | meaning
// ------+----------------------------------------------------------
// BOOT  | reset state, no request
// REQ   | request pcF on the bus (or raise AdEL if misaligned)
// DATA  | address accepted, waiting for read data
// OUT   | instruction buffered and offered to decode
// DROP  | in-flight read is stale; wait for its data and discard it
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        redirectD,
    input  logic [31:0] redirect_targetD,
    input  logic        flush_excep,
    input  logic [31:0] excep_pc,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instF,
    output logic        inst_validF,
    output logic        adelF,
    output logic        fetch_busy
);

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        REQ  = 3'd1,
        DATA = 3'd2,
        OUT  = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    logic [31:0] r_pend_target;
    logic        r_pend;
    logic        r_kill;
    logic        r_adel;

    logic        w_misalign;
    logic        w_req;
    logic        w_consume;
    logic        w_hold;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_nxt;

    assign w_misalign = (r_pc[1:0] != 2'b00);

    // A killed request was raised on an aligned address before the flush, so
    // it stays on the bus regardless of the (possibly misaligned) new pcF.
    assign w_req     = (r_state == REQ) && (r_kill || !w_misalign);
    assign w_consume = (r_state == OUT) && !stallF && !flush_excep;
    assign w_hold    = w_req && !inst_addr_ok;

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (r_pend) begin
            w_next_pc = r_pend_target;
        end else if (redirectD) begin
            w_next_pc = redirect_targetD;
        end
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (flush_excep) begin
            w_pc_nxt = excep_pc;
        end else if (w_consume) begin
            w_pc_nxt = w_next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_inst        <= 32'd0;
            r_pend_target <= 32'd0;
            r_pend        <= 1'b0;
            r_kill        <= 1'b0;
            r_adel        <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            // The bus address is decoupled from pcF so an outstanding request
            // keeps its address when a flush moves pcF underneath it.
            if (!w_hold) begin
                r_addr <= w_pc_nxt;
            end

            if (flush_excep || w_consume) begin
                r_pend <= 1'b0;
            end else if (redirectD) begin
                r_pend        <= 1'b1;
                r_pend_target <= redirect_targetD;
            end

            if (flush_excep) begin
                r_adel <= 1'b0;
            end

            case (r_state)
                BOOT: begin
                    r_state <= REQ;
                end
                REQ: begin
                    if (w_req) begin
                        if (inst_addr_ok) begin
                            r_state <= (r_kill || flush_excep) ? DROP : DATA;
                        end else if (flush_excep) begin
                            r_kill <= 1'b1;
                        end
                    end else if (!flush_excep) begin
                        r_inst  <= 32'd0;
                        r_adel  <= 1'b1;
                        r_state <= OUT;
                    end
                end
                DATA: begin
                    if (inst_data_ok) begin
                        if (r_kill || flush_excep) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                        end else begin
                            r_inst  <= inst_rdata;
                            r_state <= OUT;
                        end
                    end else if (flush_excep) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (inst_data_ok) begin
                        r_kill  <= 1'b0;
                        r_state <= REQ;
                    end
                end
                OUT: begin
                    if (flush_excep) begin
                        r_state <= REQ;
                    end else if (!stallF) begin
                        r_adel  <= 1'b0;
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign inst_req    = w_req;
    assign inst_wr     = 1'b0;
    assign inst_size   = 2'b10;
    assign inst_addr   = r_addr;
    assign inst_wdata  = 32'd0;
    assign pcF         = r_pc;
    assign instF       = r_inst;
    assign inst_validF = (r_state == OUT);
    assign adelF       = r_adel;
    assign fetch_busy  = (r_state != OUT);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b1;
    logic        redirectD = 1'b0;
    logic [31:0] redirect_targetD = 32'd0;
    logic        flush_excep = 1'b0;
    logic [31:0] excep_pc = 32'd0;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic [31:0] pcF;
    logic [31:0] instF;
    logic        inst_validF;
    logic        adelF;
    logic        fetch_busy;

    inst_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stallF(stallF),
        .redirectD(redirectD), .redirect_targetD(redirect_targetD),
        .flush_excep(flush_excep), .excep_pc(excep_pc),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .pcF(pcF), .instF(instF), .inst_validF(inst_validF),
        .adelF(adelF), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } deliv_t;

    deliv_t      sb_q[$];
    int          n_total = 0;
    int          n_bad = 0;

    // bus model state
    int          addr_wait = 0;
    int          wait_cnt = 0;
    logic        have_acc = 1'b0;
    logic [31:0] acc_addr = 32'd0;
    logic        held = 1'b0;
    logic [31:0] held_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h24080001;
        return a ^ 32'h5a5aa5a5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        deliv_t e;
        e.pc = pc; e.inst = inst; e.adel = adel;
        sb_q.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] pc);
        push_exp(pc, mem_word(pc), 1'b0);
    endtask

    // One-cycle sram-like slave: data_ok the cycle after addr_ok.
    task automatic bus_step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        if (rst) begin
            have_acc = 1'b0; wait_cnt = 0; held = 1'b0;
            return;
        end
        if (have_acc) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(acc_addr);
            have_acc     = 1'b0;
        end
        if (inst_req) begin
            if (held) chk("req_hold", inst_addr, held_addr);
            if (wait_cnt >= addr_wait) begin
                inst_addr_ok = 1'b1;
                have_acc = 1'b1;
                acc_addr = inst_addr;
                wait_cnt = 0;
                held = 1'b0;
            end else begin
                wait_cnt++;
                held = 1'b1;
                held_addr = inst_addr;
            end
        end else begin
            held = 1'b0;
        end
    endtask

    task automatic tick();
        deliv_t e;
        if (!rst && inst_validF && !stallF && !flush_excep) begin
            if (sb_q.size() > 0) e = sb_q.pop_front();
            else begin e.pc = 32'hffffffff; e.inst = 32'hffffffff; e.adel = 1'b1; end
            chk("deliv_pc", pcF, e.pc);
            chk("deliv_inst", instF, e.inst);
            chk("deliv_adel", {31'd0, adelF}, {31'd0, e.adel});
        end
        @(posedge clk);
        #1;
        bus_step();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            if (inst_validF) break;
            tick();
        end
        if (!inst_validF) chk("valid_timeout", {31'd0, inst_validF}, 32'd1);
    endtask

    task automatic consume();
        wait_valid();
        stallF = 1'b0;
        tick();
        stallF = 1'b1;
    endtask

    initial begin
        // reset
        tick(); tick();
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_validF}, 32'd0);
        chk("rst_inst", instF, 32'd0);
        chk("rst_adel", {31'd0, adelF}, 32'd0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd1);
        chk("rst_pc", pcF, RESET_PC);
        rst = 1'b0;

        // first fetch, zero-wait latency
        push_word(RESET_PC);
        tick();
        chk("first_req", {31'd0, inst_req}, 32'd1);
        chk("first_addr", inst_addr, RESET_PC);
        tick();
        chk("lat_valid_n1", {31'd0, inst_validF}, 32'd0);
        tick();
        chk("lat_valid_n2", {31'd0, inst_validF}, 32'd1);
        chk("first_inst", instF, 32'h24080001);
        chk("first_busy", {31'd0, fetch_busy}, 32'd0);
        consume();
        chk("seq_addr", inst_addr, 32'hbfc00004);

        // stall held five cycles in OUT
        push_word(32'hbfc00004);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", pcF, 32'hbfc00004);
            chk("stall_inst", instF, mem_word(32'hbfc00004));
            chk("stall_req", {31'd0, inst_req}, 32'd0);
        end
        consume();
        chk("stall_next", inst_addr, 32'hbfc00008);

        // branch at bfc00010, redirect while delay slot is in DATA
        push_word(32'hbfc00008); consume();
        push_word(32'hbfc0000c); consume();
        push_word(32'hbfc00010); consume();
        tick();
        redirectD = 1'b1; redirect_targetD = 32'hbfc00100;
        tick();
        redirectD = 1'b0;
        push_word(32'hbfc00014); consume();
        chk("br_pend_addr", inst_addr, 32'hbfc00100);
        chk("br_pend_req", {31'd0, inst_req}, 32'd1);

        // redirect asserted in the delay-slot consuming cycle
        push_word(32'hbfc00100); consume();
        push_word(32'hbfc00104); consume();
        push_word(32'hbfc00108);
        wait_valid();
        redirectD = 1'b1; redirect_targetD = 32'hbfc00200;
        consume();
        redirectD = 1'b0;
        chk("br_now_addr", inst_addr, 32'hbfc00200);

        // flush in REQ with addr_ok delayed
        push_word(32'hbfc00200);
        wait_valid();
        addr_wait = 3;
        consume();
        flush_excep = 1'b1; excep_pc = 32'hbfc00380;
        tick();
        flush_excep = 1'b0;
        chk("fl_req_addr", inst_addr, 32'hbfc00204);
        chk("fl_req_req", {31'd0, inst_req}, 32'd1);
        chk("fl_req_pc", pcF, 32'hbfc00380);
        push_word(32'hbfc00380);
        for (int i = 0; i < 30; i++) begin
            if (inst_req && inst_addr != 32'hbfc00204) break;
            tick();
        end
        chk("fl_req_next", inst_addr, 32'hbfc00380);
        addr_wait = 0;
        consume();

        // flush in DATA with data_ok; also cancels a pending redirect
        redirectD = 1'b1; redirect_targetD = 32'hbfc00500;
        tick();
        redirectD = 1'b0;
        chk("fl_data_ok", {31'd0, inst_data_ok}, 32'd1);
        flush_excep = 1'b1; excep_pc = 32'hbfc00380;
        tick();
        flush_excep = 1'b0;
        chk("fl_data_req", {31'd0, inst_req}, 32'd1);
        chk("fl_data_addr", inst_addr, 32'hbfc00380);
        push_word(32'hbfc00380); consume();
        chk("fl_pend_cancel", inst_addr, 32'hbfc00384);

        // misaligned redirect target
        push_word(32'hbfc00384); consume();
        redirectD = 1'b1; redirect_targetD = 32'hbfc00102;
        tick();
        redirectD = 1'b0;
        push_word(32'hbfc00388);
        push_exp(32'hbfc00102, 32'd0, 1'b1);
        consume();
        chk("adel_noreq", {31'd0, inst_req}, 32'd0);
        chk("adel_pc", pcF, 32'hbfc00102);
        tick();
        chk("adel_flag", {31'd0, adelF}, 32'd1);
        chk("adel_inst", instF, 32'd0);
        chk("adel_valid", {31'd0, inst_validF}, 32'd1);
        consume();
        chk("adel_clear", {31'd0, adelF}, 32'd0);
        chk("adel_next_pc", pcF, 32'hbfc00106);

        chk("sb_left", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
